// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg -- shared constants and types for the RAM port arbiter.
//   MAX_PORTS    : upper bound on requesting ports (sizes the index field)
//   MAX_LATENCY  : upper bound on RAM read latency
//   pipe_entry_t : response-tracking entry {valid, idx, lane} carried
//                  alongside the RAM access until its data returns
package ram_arb_pkg;

  localparam int MAX_PORTS   = 8;
  localparam int MAX_LATENCY = 4;

  localparam int IDX_W  = $clog2(MAX_PORTS);  // 3 bits
  localparam int LANE_W = 4;                  // up to 16 sub-word lanes

  typedef struct packed {
    logic              valid;
    logic [IDX_W-1:0]  idx;
    logic [LANE_W-1:0] lane;
  } pipe_entry_t;

endpackage

// File: rtl/ram_arbiter_np_if.sv
// ram_arbiter_np_if -- bundle of port-side and RAM-side buses of the arbiter.
//   Port side (flattened, port p in slice p):
//     port_req_i, port_gnt_o, port_rvalid_o, port_addr_i, port_we_i,
//     port_be_i, port_wdata_i, port_rdata_o
//   RAM side:
//     ram_en_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o, ram_rdata_i
//   Modports:
//     slave  : the arbiter itself
//     master : the requesters plus the RAM (bench / surrounding fabric)
interface ram_arbiter_np_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 64
);

  logic [NUM_PORTS-1:0]              port_req_i;
  logic [NUM_PORTS-1:0]              port_gnt_o;
  logic [NUM_PORTS-1:0]              port_rvalid_o;
  logic [NUM_PORTS*ADDR_WIDTH-1:0]   port_addr_i;
  logic [NUM_PORTS-1:0]              port_we_i;
  logic [NUM_PORTS*IN_WIDTH/8-1:0]   port_be_i;
  logic [NUM_PORTS*IN_WIDTH-1:0]     port_wdata_i;
  logic [NUM_PORTS*IN_WIDTH-1:0]     port_rdata_o;

  logic                              ram_en_o;
  logic                              ram_we_o;
  logic [ADDR_WIDTH-1:0]             ram_addr_o;
  logic [OUT_WIDTH/8-1:0]            ram_be_o;
  logic [OUT_WIDTH-1:0]              ram_wdata_o;
  logic [OUT_WIDTH-1:0]              ram_rdata_i;

  modport slave (
    input  port_req_i, port_addr_i, port_we_i, port_be_i, port_wdata_i,
    input  ram_rdata_i,
    output port_gnt_o, port_rvalid_o, port_rdata_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o
  );

  modport master (
    output port_req_i, port_addr_i, port_we_i, port_be_i, port_wdata_i,
    output ram_rdata_i,
    input  port_gnt_o, port_rvalid_o, port_rdata_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o
  );

endinterface

// File: rtl/ram_arb_rr.sv
// ram_arb_rr -- single-grant arbiter for the RAM ports.
//   Build option RAM_ARB_RR_EN:
//     defined   : round-robin; grant the lowest requesting index >= pointer
//                 (wrapping), pointer moves to granted+1 after each grant and
//                 holds while nobody requests.
//     undefined : fixed priority, port 0 highest, no pointer register.
//   Ports:
//     clk, rst_n : clock, async active-low reset (pointer only)
//     req        : per-port request
//     gnt        : combinational one-hot grant (zero when no request)
//     gnt_idx    : binary index of the granted port (0 when no request)
module ram_arb_rr
  import ram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]     gnt_idx
);

`ifdef RAM_ARB_RR_EN

  logic [IDX_W-1:0] ptr;

  // NOTE: every output of a combinational block is given a default before
  // any conditional assignment so that no path leaves it unassigned (which
  // would infer a latch).
  always_comb begin
    logic found;
    int   cand;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (|req) begin
      // An idle cycle leaves the pointer untouched.
      ptr <= (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

`else

  // Fixed priority has no state; clk/rst_n are kept for a uniform port list.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  always_comb begin
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req[i]) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
  end

`endif

endmodule

// File: rtl/ram_arbiter_np.sv
// ram_arbiter_np -- shares one wide RAM between NUM_PORTS narrow ports.
//   Each cycle one requesting port is granted combinationally; its access is
//   driven onto the RAM with write data replicated across all lanes and byte
//   enables steered to the lane selected by the address. A RAM_LATENCY-deep
//   tracking pipeline returns a one-cycle rvalid (reads and writes) to the
//   granted port exactly RAM_LATENCY cycles later, with read data taken from
//   the matching lane of ram_rdata_i.
//   Build option RAM_ARB_RR_EN selects round-robin arbitration (see
//   ram_arb_rr); without it arbitration is fixed priority, port 0 highest.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : ram_arbiter_np_if.slave -- port-side and RAM-side signals
module ram_arbiter_np
  import ram_arb_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int OUT_WIDTH   = 64,
  parameter int IN_WIDTH    = 32,
  parameter int RAM_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_arbiter_np_if.slave  bus
);

  localparam int IN_BYTES  = IN_WIDTH / 8;
  localparam int OUT_BYTES = OUT_WIDTH / 8;
  localparam int LANES     = OUT_WIDTH / IN_WIDTH;
  localparam int LANE_LO   = $clog2(IN_BYTES);
  localparam int LANE_HI   = $clog2(OUT_BYTES);

  if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
    $error("ram_arbiter_np: NUM_PORTS out of range");
  end
  if (RAM_LATENCY < 1 || RAM_LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("ram_arbiter_np: RAM_LATENCY out of range");
  end
  if (LANES > (1 << LANE_W)) begin : g_bad_lanes
    $error("ram_arbiter_np: OUT_WIDTH/IN_WIDTH exceeds lane field");
  end

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic [NUM_PORTS-1:0] gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 any_req;

  assign any_req = |bus.port_req_i;

  ram_arb_rr #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.port_req_i),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.port_gnt_o = gnt;

  // ---------------------------------------------------------------------
  // Per-port unpacking and lane extraction
  // ---------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] addr_a  [NUM_PORTS];
  logic [IN_BYTES-1:0]   be_a    [NUM_PORTS];
  logic [IN_WIDTH-1:0]   wdata_a [NUM_PORTS];
  logic [LANE_W-1:0]     lane_a  [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign addr_a[p]  = bus.port_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign be_a[p]    = bus.port_be_i[p*IN_BYTES +: IN_BYTES];
    assign wdata_a[p] = bus.port_wdata_i[p*IN_WIDTH +: IN_WIDTH];
    if (LANES > 1) begin : g_lane
      // Address bits between the port word and the RAM word pick the lane.
      assign lane_a[p] = LANE_W'(addr_a[p][LANE_HI-1:LANE_LO]);
    end else begin : g_no_lane
      assign lane_a[p] = '0;
    end
  end

  // ---------------------------------------------------------------------
  // Granted-port select (one-hot AND-OR)
  // ---------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_we;
  logic [IN_BYTES-1:0]   sel_be;
  logic [IN_WIDTH-1:0]   sel_wdata;
  logic [LANE_W-1:0]     sel_lane;

  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_wdata = '0;
    sel_lane  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt[p]) begin
        sel_addr  = addr_a[p];
        sel_we    = bus.port_we_i[p];
        sel_be    = be_a[p];
        sel_wdata = wdata_a[p];
        sel_lane  = lane_a[p];
      end
    end
  end

  // ---------------------------------------------------------------------
  // RAM request side
  // ---------------------------------------------------------------------
  assign bus.ram_en_o    = any_req;
  assign bus.ram_we_o    = sel_we;
  assign bus.ram_addr_o  = sel_addr;
  // Byte enables land in the addressed lane only; other lanes stay zero.
  assign bus.ram_be_o    = OUT_BYTES'(sel_be) << (int'(sel_lane) * IN_BYTES);
  // Data is replicated so whichever lane is enabled sees the port word.
  assign bus.ram_wdata_o = {LANES{sel_wdata}};

  // ---------------------------------------------------------------------
  // Response tracking pipeline
  // ---------------------------------------------------------------------
  pipe_entry_t pipe [RAM_LATENCY];
  pipe_entry_t pipe_in;
  pipe_entry_t pipe_out;

  assign pipe_in = '{valid: any_req, idx: gnt_idx, lane: sel_lane};

  // NOTE: the tracking entries are reset (unlike a RAM array would be) so
  // that grants in flight when reset asserts never produce an rvalid later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAM_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= pipe_in;
      for (int i = 1; i < RAM_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign pipe_out = pipe[RAM_LATENCY-1];

  // ---------------------------------------------------------------------
  // Response return side
  // ---------------------------------------------------------------------
  logic [IN_WIDTH-1:0]           resp_word;
  logic [NUM_PORTS-1:0]          rvalid;
  logic [NUM_PORTS*IN_WIDTH-1:0] rdata;

  assign resp_word = bus.ram_rdata_i[int'(pipe_out.lane) * IN_WIDTH +: IN_WIDTH];

  always_comb begin
    rvalid = '0;
    rdata  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (pipe_out.valid && pipe_out.idx == IDX_W'(p)) begin
        rvalid[p]                    = 1'b1;
        rdata[p*IN_WIDTH +: IN_WIDTH] = resp_word;
      end
    end
  end

  assign bus.port_rvalid_o = rvalid;
  assign bus.port_rdata_o  = rdata;

endmodule

// File: tb/tb_ram_arbiter_np.sv
// tb_ram_arbiter_np -- directed bench for ram_arbiter_np
// (NUM_PORTS=4, IN_WIDTH=32, OUT_WIDTH=64, RAM_LATENCY=2).
// Expectations depend on RAM_ARB_RR_EN exactly as the design does.
module tb_ram_arbiter_np;
  import ram_arb_pkg::*;

  localparam int NP  = 4;
  localparam int AW  = 32;
  localparam int IW  = 32;
  localparam int OW  = 64;
  localparam int LAT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_np_if #(
    .NUM_PORTS (NP), .ADDR_WIDTH (AW), .IN_WIDTH (IW), .OUT_WIDTH (OW)
  ) bus ();

  ram_arbiter_np #(
    .NUM_PORTS (NP), .ADDR_WIDTH (AW), .OUT_WIDTH (OW),
    .IN_WIDTH (IW), .RAM_LATENCY (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ------------------------------------------------------------------
  // RAM model: 128 x 64-bit words, 2-cycle read latency
  // ------------------------------------------------------------------
  logic [63:0] mem [128];
  logic [63:0] rd_d1 = '0;
  logic [63:0] rd_d2 = '0;
  logic [6:0]  ram_word;

  assign ram_word        = bus.ram_addr_o[9:3];
  assign bus.ram_rdata_i = rd_d2;

  always @(posedge clk) begin
    if (bus.ram_en_o && bus.ram_we_o) begin
      for (int b = 0; b < 8; b++)
        if (bus.ram_be_o[b]) mem[ram_word][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
    end
    rd_d1 <= (bus.ram_en_o && !bus.ram_we_o) ? mem[ram_word] : 64'h0;
    rd_d2 <= rd_d1;
  end

  // ------------------------------------------------------------------
  // Counters, check task, scoreboard
  // ------------------------------------------------------------------
  int n_cmp   = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int rv_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          port;
    logic [31:0] data;
    bit          chk;
    int          due;
  } exp_t;

  exp_t sb[$];

  task automatic expect_resp(input int port, input logic [31:0] data, input bit chk);
    exp_t e;
    e.port = port;
    e.data = data;
    e.chk  = chk;
    e.due  = cyc + LAT;
    sb.push_back(e);
  endtask

  function automatic logic [NP-1:0] onehot(input int p);
    return NP'(1) << p;
  endfunction

  // Monitor: every presented response is matched against the queue head.
  initial begin
    exp_t               e;
    logic [NP*IW-1:0]   exp_rd;
    forever begin
      @(negedge clk);
      if (bus.port_rvalid_o !== '0) begin
        rv_seen++;
        if (sb.size() == 0) begin
          check("unexpected_rvalid", bus.port_rvalid_o, '0);
        end else begin
          e = sb.pop_front();
          check("rvalid_vec", bus.port_rvalid_o, onehot(e.port));
          check("resp_cycle", cyc, e.due);
          if (e.chk) begin
            exp_rd = '0;
            exp_rd[e.port*IW +: IW] = e.data;
            check("rdata_bus", bus.port_rdata_o, exp_rd);
          end
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input bit req, input bit we,
                          input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata);
    bus.port_req_i[p]           = req;
    bus.port_we_i[p]            = we;
    bus.port_addr_i[p*AW +: AW] = addr;
    bus.port_be_i[p*4 +: 4]     = be;
    bus.port_wdata_i[p*IW +: IW] = wdata;
  endtask

  task automatic idle_all();
    bus.port_req_i = '0;
    bus.port_we_i  = '0;
  endtask

  // Expected grant sequences for the contention tests.
  int all_order [5];
  int pair_order[4];
  int gap_second;

  // ------------------------------------------------------------------
  // Main sequence
  // ------------------------------------------------------------------
  initial begin
    int rv0;

`ifdef RAM_ARB_RR_EN
    all_order  = '{0, 1, 2, 3, 0};
    pair_order = '{1, 3, 1, 3};
    gap_second = 3;
`else
    all_order  = '{0, 0, 0, 0, 0};
    pair_order = '{1, 1, 1, 1};
    gap_second = 0;
`endif

    for (int i = 0; i < 128; i++) mem[i] <= 64'h0;
    mem[7'h20] <= 64'hAAAA_BBBB_1111_2222;
    for (int p = 0; p < NP; p++)
      mem[7'h40 + p] <= {32'hC0DE_0000 + 32'(p), 32'hBEEF_0000 + 32'(p)};

    bus.port_req_i   = '0;
    bus.port_we_i    = '0;
    bus.port_addr_i  = '0;
    bus.port_be_i    = '0;
    bus.port_wdata_i = '0;

    // Reset: combinational grant follows requests with pointer 0.
    set_port(1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
    set_port(3, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
    @(negedge clk);
    check("rst_gnt", bus.port_gnt_o, 4'b0010);
    check("rst_ram_en", bus.ram_en_o, 1'b1);
    check("rst_rvalid", bus.port_rvalid_o, 4'b0000);
    idle_all();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single read: port 2, addr 0x104 -> upper lane.
    set_port(2, 1'b1, 1'b0, 32'h104, 4'hF, 32'h0);
    @(negedge clk);
    check("rd_gnt", bus.port_gnt_o, 4'b0100);
    check("rd_en", bus.ram_en_o, 1'b1);
    check("rd_we", bus.ram_we_o, 1'b0);
    check("rd_addr", bus.ram_addr_o, 32'h104);
    check("rd_be", bus.ram_be_o, 8'hF0);
    expect_resp(2, 32'hAAAA_BBBB, 1'b1);
    tick();
    idle_all();
    @(negedge clk);
    check("rd_idle_en", bus.ram_en_o, 1'b0);
    repeat (3) tick();

    // Write: port 0, addr 0x0, be 0x3.
    set_port(0, 1'b1, 1'b1, 32'h0, 4'h3, 32'h1234_5678);
    @(negedge clk);
    check("wr_gnt", bus.port_gnt_o, 4'b0001);
    check("wr_be", bus.ram_be_o, 8'h03);
    check("wr_wdata", bus.ram_wdata_o, 64'h1234_5678_1234_5678);
    check("wr_we", bus.ram_we_o, 1'b1);
    expect_resp(0, 32'h0, 1'b0);
    tick();
    // Read-back of the written lane through port 1.
    set_port(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_port(1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
    @(negedge clk);
    check("rb_gnt", bus.port_gnt_o, 4'b0010);
    check("rb_be", bus.ram_be_o, 8'h0F);
    expect_resp(1, 32'h0000_5678, 1'b1);
    tick();
    idle_all();
    repeat (4) tick();

    // Reset mid-operation: grant in cycle 0, reset cycles 1..2, release at 3.
    rv0 = rv_seen;
    set_port(1, 1'b1, 1'b0, 32'h208, 4'hF, 32'h0);
    @(negedge clk);
    check("mr_gnt", bus.port_gnt_o, 4'b0010);
    tick();
    idle_all();
    rst_n = 1'b0;
    tick();
    set_port(1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
    set_port(3, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
    @(negedge clk);
    check("mr_rst_gnt", bus.port_gnt_o, 4'b0010);
    tick();
    idle_all();
    rst_n = 1'b1;
    repeat (4) tick();
    check("mr_no_rvalid", rv_seen, rv0);

    // All four ports contend continuously for five cycles.
    for (int p = 0; p < NP; p++)
      set_port(p, 1'b1, 1'b0, 32'h200 + 32'(8*p), 4'hF, 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("all_gnt%0d", k), bus.port_gnt_o, onehot(all_order[k]));
      expect_resp(all_order[k], 32'hBEEF_0000 + 32'(all_order[k]), 1'b1);
      tick();
    end
    idle_all();
    repeat (4) tick();

    // Ports 1 and 3 contend continuously for four cycles.
    set_port(1, 1'b1, 1'b0, 32'h208, 4'hF, 32'h0);
    set_port(3, 1'b1, 1'b0, 32'h218, 4'hF, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("pair_gnt%0d", k), bus.port_gnt_o, onehot(pair_order[k]));
      expect_resp(pair_order[k], 32'hBEEF_0000 + 32'(pair_order[k]), 1'b1);
      tick();
    end
    idle_all();
    repeat (4) tick();

    // Idle gap: requests in cycles 0 and 5, pointer must hold across it.
    set_port(2, 1'b1, 1'b0, 32'h210, 4'hF, 32'h0);
    set_port(3, 1'b1, 1'b0, 32'h218, 4'hF, 32'h0);
    @(negedge clk);
    check("gap_gnt0", bus.port_gnt_o, 4'b0100);
    expect_resp(2, 32'hBEEF_0002, 1'b1);
    tick();
    idle_all();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("gap_en%0d", k), bus.ram_en_o, 1'b0);
      check($sformatf("gap_gnt_idle%0d", k), bus.port_gnt_o, 4'b0000);
      tick();
    end
    set_port(0, 1'b1, 1'b0, 32'h200, 4'hF, 32'h0);
    set_port(3, 1'b1, 1'b0, 32'h218, 4'hF, 32'h0);
    @(negedge clk);
    check("gap_gnt5", bus.port_gnt_o, onehot(gap_second));
    expect_resp(gap_second, 32'hBEEF_0000 + 32'(gap_second), 1'b1);
    tick();
    idle_all();
    repeat (5) tick();

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ram_arbiter_np.md
RAM_ARBITER_NP -- requirements
Module: ram_arbiter_np

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of requesting ports, 2..8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: byte address width.
REQ-003 SHALL have parameter OUT_WIDTH, default 64: RAM data width, a power of two, at least 32.
REQ-004 SHALL have parameter IN_WIDTH, default 32: width of every port, a power of two, 8 to OUT_WIDTH.
REQ-005 SHALL have parameter RAM_LATENCY, default 1: cycles from RAM enable to valid ram_rdata_i, 1..4.
REQ-006 SHALL have clk, input, 1: clock; all state on rising edge.
REQ-007 SHALL have rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port_req_i, input, NUM_PORTS: per-port request.
REQ-009 SHALL have port_gnt_o, output, NUM_PORTS: per-port grant, combinational, at most one bit set.
REQ-010 SHALL have port_rvalid_o, output, NUM_PORTS: per-port read/write response valid.
REQ-011 SHALL have port_addr_i, input, NUM_PORTS*ADDR_WIDTH: port p occupies slice p.
REQ-012 SHALL have port_we_i, input, NUM_PORTS: write enable.
REQ-013 SHALL have port_be_i, input, NUM_PORTS*IN_WIDTH/8: byte enables.
REQ-014 SHALL have port_wdata_i, input, NUM_PORTS*IN_WIDTH: write data.
REQ-015 SHALL have port_rdata_o, output, NUM_PORTS*IN_WIDTH: read data, valid while the matching rvalid bit is set.
REQ-016 SHALL have ram_en_o/ram_we_o, output, 1 each: RAM enable and write enable.
REQ-017 SHALL have ram_addr_o, output, ADDR_WIDTH: RAM address.
REQ-018 SHALL have ram_be_o, output, OUT_WIDTH/8: RAM byte enables.
REQ-019 SHALL have ram_wdata_o, output, OUT_WIDTH: RAM write data.
REQ-020 SHALL have ram_rdata_i, input, OUT_WIDTH: RAM read data.

Function
REQ-021 SHALL grant exactly one requesting port per cycle, with zero-cycle grant, while any port_req_i bit is set.
REQ-022 SHALL drive ram_en_o = |port_req_i, and drive ram_addr_o, ram_we_o, ram_be_o and ram_wdata_o from the granted port.
REQ-023 SHALL form ram_be_o as port_be_i shifted to sub-word lane addr[$clog2(OUT_WIDTH/8)-1:$clog2(IN_WIDTH/8)], with zeros elsewhere; for IN_WIDTH==OUT_WIDTH, be SHALL pass through.
REQ-024 SHALL replicate port wdata OUT_WIDTH/IN_WIDTH times on ram_wdata_o.
REQ-025 SHALL push {valid, granted index, lane} into a RAM_LATENCY-deep shift pipeline every cycle, with valid=0 when idle.
REQ-026 SHALL assert port_rvalid_o[p] for one cycle exactly RAM_LATENCY cycles after port p's grant, for both reads and writes.
REQ-027 SHALL set port_rdata_o[p] to the ram_rdata_i lane given by the pipeline output lane when that entry's index is p, and to zero otherwise.
REQ-028 SHALL sustain back-to-back grants every cycle; responses SHALL return in grant order with no bubbles.
REQ-029 SHALL hold the round-robin pointer when no port requests; an idle cycle SHALL NOT alter arbitration state.
REQ-030 SHALL treat a request dropped without a grant as never issued, with no response.

Reset
REQ-031 SHALL on reset clear every port_rvalid_o bit and every pipeline valid bit, and zero the pipeline index/lane fields and the round-robin pointer.
REQ-032 SHALL discard outstanding responses when reset asserts mid-operation; no rvalid SHALL follow reset release for pre-reset grants.
REQ-033 SHALL keep combinational outputs as functions of inputs during reset; port_gnt_o follows requests (fixed-priority order with pointer=0).

Configuration
REQ-034 SHALL, with RAM_ARB_RR_EN defined, use round-robin: grant the lowest requesting index >= pointer, wrapping modulo NUM_PORTS; the pointer SHALL become (granted+1) mod NUM_PORTS after each grant.
REQ-035 SHALL, without RAM_ARB_RR_EN, use fixed priority (port 0 highest), with no pointer register.

Structure
REQ-036 SHALL place a shared package ram_arb_pkg holding the MAX_PORTS=8 constant, the max latency constant 4, and the pipeline entry typedef {valid, idx[2:0], lane[3:0]}.
REQ-037 SHALL put the arbitration logic (pointer and grant vector) in sub-module ram_arb_rr; the width adaptation SHALL stay in generate loops in the top.

Verification (NUM_PORTS=4, IN_WIDTH=32, OUT_WIDTH=64, RAM_LATENCY=2)
REQ-038 SHALL test a single read: port 2 reads addr 0x104, RAM returns 0xAAAA_BBBB_1111_2222 -> gnt[2] in cycle 0, ram_be_o=0xF0, rvalid[2] in cycle 2, rdata[2]=0xAAAA_BBBB.
REQ-039 SHALL test round-robin (RAM_ARB_RR_EN): all 4 ports request continuously -> grant order 0,1,2,3,0; responses 2 cycles later in the same order.
REQ-040 SHALL test fixed priority (no macro): ports 1 and 3 request continuously -> port 1 granted every cycle; port 3 never granted.
REQ-041 SHALL test a write: port 0 writes addr 0x0, be=0x3, wdata=0x1234_5678 -> ram_be_o=0x03, ram_wdata_o=0x1234_5678_1234_5678, ram_we_o=1, rvalid[0] 2 cycles later.
REQ-042 SHALL test reset mid-operation: grant at cycle 0, rst_n low in cycle 1, released in cycle 3 -> no rvalid ever asserted, and pointer=0.
REQ-043 SHALL test idle gaps: requests at cycles 0 and 5 -> ram_en_o=0 in cycles 1-4, and the pointer holds across the gap.
